// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcodes, ALU select codes, decode/bundle types and helpers for the decode stage
package id_stage_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_XOR = 5'd3,
        ALU_OR  = 5'd4,
        ALU_AND = 5'd5
    } alusel_e;

    typedef struct packed {
        alusel_e         alusel;
        logic [7:0]      aluop;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            op1_zero;
        logic            rd_we;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic [XLEN-1:0]       op1;
        logic [XLEN-1:0]       op2;
        logic [7:0]            aluop;
        logic [4:0]            alusel;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic                  illegal;
        logic [XLEN-1:0]       pc;
    } ex_bundle_t;

    // Immediates are always sign-extended from bit 31 of the 32-bit field
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // The funct3 values shared by the register and immediate arithmetic forms
    function automatic alusel_e f3_sel(input logic [2:0] f3);
        return (f3 == F3_ADD) ? ALU_ADD :
               (f3 == F3_XOR) ? ALU_XOR :
               (f3 == F3_OR)  ? ALU_OR  :
               (f3 == F3_AND) ? ALU_AND : ALU_NOP;
    endfunction

    // x0 reads as zero; a matching write-back in the same cycle wins over the register file
    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [XLEN-1:0]       rf,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wa,
        input logic [XLEN-1:0]       wd
    );
        return (rs == '0) ? '0 : (we && wa == rs) ? wd : rf;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch, register-file, write-back and execute signals of the decode stage
interface id_stage_if;
    import id_stage_pkg::*;

    logic                  flush_i;
    logic                  inst_valid_i;
    logic                  inst_ready_o;
    logic [31:0]           inst_i;
    logic [XLEN-1:0]       pc_i;
    logic [REG_ADDR_W-1:0] rs1_addr_o;
    logic [REG_ADDR_W-1:0] rs2_addr_o;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic                  wb_we_i;
    logic [REG_ADDR_W-1:0] wb_addr_i;
    logic [XLEN-1:0]       wb_data_i;
    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic [XLEN-1:0]       oprand1;
    logic [XLEN-1:0]       oprand2;
    logic [7:0]            aluop_o;
    logic [4:0]            alusel_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic                  rd_we_o;
    logic                  illegal_o;
    logic [XLEN-1:0]       pc_o;

    modport slave (
        input  flush_i, inst_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i,
               wb_we_i, wb_addr_i, wb_data_i, ex_ready_i,
        output inst_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, oprand1, oprand2,
               aluop_o, alusel_o, rd_addr_o, rd_we_o, illegal_o, pc_o
    );

    modport master (
        output flush_i, inst_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i,
               wb_we_i, wb_addr_i, wb_data_i, ex_ready_i,
        input  inst_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, oprand1, oprand2,
               aluop_o, alusel_o, rd_addr_o, rd_we_o, illegal_o, pc_o
    );

endinterface

// File: rtl/id_decoder.sv
// id_decoder: combinational instruction-to-control decode for the supported RV64 ALU subset
module id_decoder
    import id_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    alusel_e    f3_alu;
    alusel_e    sel;

    assign opcode = inst_i[6:0];
    assign funct7 = inst_i[31:25];
    assign funct3 = inst_i[14:12];
    assign f3_alu = f3_sel(funct3);

    // Anything outside the decode table falls through to NOP and is flagged illegal
    always_comb begin
        sel = (opcode == OPC_LUI)                                          ? ALU_ADD :
              (opcode == OPC_OP_IMM)                                       ? f3_alu  :
              (opcode == OPC_OP && funct7 == F7_BASE)                      ? f3_alu  :
              (opcode == OPC_OP && funct7 == F7_ALT && funct3 == F3_ADD)   ? ALU_SUB : ALU_NOP;
        dec_o.alusel   = sel;
        dec_o.aluop    = {opcode[6:2], funct3};
        dec_o.imm      = (opcode == OPC_LUI) ? sext32({inst_i[31:12], 12'b0})
                                             : sext32({{20{inst_i[31]}}, inst_i[31:20]});
        dec_o.use_imm  = opcode != OPC_OP;
        dec_o.op1_zero = opcode == OPC_LUI;
        dec_o.illegal  = sel == ALU_NOP;
        dec_o.rd_we    = (sel != ALU_NOP) && (inst_i[11:7] != '0);
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV64 decode stage with operand bypass and a one-entry valid/ready register toward execute
module id_stage
    import id_stage_pkg::*;
(
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  io
);

    dec_t            dec;
    ex_bundle_t      bundle_d, bundle_q;
    logic            valid_d, valid_q;
    logic            accept;
    logic [XLEN-1:0] rs1_val, rs2_val;

    id_decoder u_dec (
        .inst_i (io.inst_i),
        .dec_o  (dec)
    );

    assign io.rs1_addr_o   = io.inst_i[19:15];
    assign io.rs2_addr_o   = io.inst_i[24:20];
    assign io.inst_ready_o = !rst && !io.flush_i && (!valid_q || io.ex_ready_i);
    assign accept          = io.inst_valid_i && io.inst_ready_o;

    assign rs1_val = fwd(io.rs1_addr_o, io.rs1_data_i, io.wb_we_i, io.wb_addr_i, io.wb_data_i);
    assign rs2_val = fwd(io.rs2_addr_o, io.rs2_data_i, io.wb_we_i, io.wb_addr_i, io.wb_data_i);

    // Flush wins, then a new accept, then a drain by execute; otherwise the bundle is held
    assign valid_d = io.flush_i ? 1'b0 : accept ? 1'b1 : io.ex_ready_i ? 1'b0 : valid_q;

    // Capture a freshly decoded bundle on accept, otherwise keep the held one stable
    always_comb begin
        bundle_d = bundle_q;
        if (accept) begin
            bundle_d.op1     = dec.op1_zero ? '0 : rs1_val;
            bundle_d.op2     = dec.use_imm ? dec.imm : rs2_val;
            bundle_d.aluop   = dec.aluop;
            bundle_d.alusel  = dec.alusel;
            bundle_d.rd      = io.inst_i[11:7];
            bundle_d.rd_we   = dec.rd_we;
            bundle_d.illegal = dec.illegal;
            bundle_d.pc      = io.pc_i;
        end
    end

    // Pipeline register; reset clears everything, which also makes alusel NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign io.ex_valid_o = valid_q;
    assign io.oprand1    = bundle_q.op1;
    assign io.oprand2    = bundle_q.op2;
    assign io.aluop_o    = bundle_q.aluop;
    assign io.alusel_o   = bundle_q.alusel;
    assign io.rd_addr_o  = bundle_q.rd;
    assign io.rd_we_o    = bundle_q.rd_we;
    assign io.illegal_o  = bundle_q.illegal;
    assign io.pc_o       = bundle_q.pc;

endmodule
